// File: rtl/pci_pkg.sv
// rtl/pci_pkg.sv - command codes, target FSM state encoding and default storage depth
package pci_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TURN  = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_RDATA = 3'd3;
  localparam logic [2:0] ST_DISC  = 3'd4;
  localparam logic [2:0] ST_BUSY  = 3'd5;

  localparam int unsigned PCI_DEPTH = 3;

endpackage

// File: rtl/pci_addr_decode.sv
// rtl/pci_addr_decode.sv - address-phase window/command decode for the PCI target
module pci_addr_decode
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = PCI_DEPTH
) (
  input  logic [31:2] ad_i,
  input  logic [3:0]  cbe_n_i,
  output logic        hit_o,
  output logic        cmd_ok_o,
  output logic        is_wr_o
);

  // Only 16-byte granularity is decoded; the word index must also fall inside storage.
  assign hit_o    = (ad_i[31:4] == BASE_ADDR[31:4]) && ({30'b0, ad_i[3:2]} < DEPTH);
  assign cmd_ok_o = (cbe_n_i == CMD_MEM_READ) || (cbe_n_i == CMD_MEM_WRITE);
  assign is_wr_o  = (cbe_n_i == CMD_MEM_WRITE);

endmodule

// File: rtl/pci_target_ctrl.sv
// rtl/pci_target_ctrl.sv - PCI target FSM driving DEVSEL#/TRDY#/STOP# and storage strobes
module pci_target_ctrl
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = PCI_DEPTH,
  parameter int unsigned ADDR_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_n,
  input  logic              irdy_n,
  input  logic [3:0]        cbe_n,
  input  logic [31:0]       ad,
  input  logic              trdy_control,
  output logic              devsel_n,
  output logic              trdy_n,
  output logic              stop_n,
  output logic              f,
  output logic              re,
  output logic              we,
  output logic [3:0]        be,
  output logic [ADDR_W-1:0] address
);

  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              devsel_q, devsel_d, trdy_q, trdy_d, stop_q, stop_d;
  logic              f_q, f_d, re_q, re_d, we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hit, cmd_ok, is_wr, beat, release_out;
  logic              unused_ad;

  assign unused_ad = ^ad[1:0];

  pci_addr_decode #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) u_decode (
    .ad_i     (ad[31:2]),
    .cbe_n_i  (cbe_n),
    .hit_o    (hit),
    .cmd_ok_o (cmd_ok),
    .is_wr_o  (is_wr)
  );

  assign beat = !irdy_n && !trdy_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    devsel_d    = devsel_q;
    trdy_d      = trdy_q;
    stop_d      = stop_q;
    f_d         = f_q;
    re_d        = re_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    release_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!frame_n) begin
          if (hit && cmd_ok) begin
            devsel_d = 1'b0;
            f_d      = 1'b0;
            cnt_d    = '0;
            addr_d   = ad[ADDR_W+1:2];
            if (is_wr) begin
              state_d = ST_WDATA;
              we_d    = 1'b1;
              trdy_d  = !trdy_control;
            end else begin
              state_d = ST_TURN;
              re_d    = 1'b1;
              trdy_d  = 1'b1;
            end
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_TURN: begin
        state_d = ST_RDATA;
        be_d    = ~cbe_n;
        trdy_d  = !trdy_control;
      end
      ST_WDATA, ST_RDATA: begin
        be_d = ~cbe_n;
        if (beat) cnt_d = cnt_q + CNT_W'(1);
        // A completing final beat wins over the burst-length disconnect.
        if (beat && frame_n) begin
          state_d     = ST_IDLE;
          release_out = 1'b1;
        end else if (cnt_d == CNT_MAX) begin
          state_d = ST_DISC;
          stop_d  = 1'b0;
          trdy_d  = 1'b1;
        end else begin
          trdy_d = !(trdy_control && (cnt_d < CNT_MAX));
        end
      end
      ST_DISC: begin
        if (frame_n) begin
          state_d     = ST_BUSY;
          release_out = 1'b1;
        end
      end
      ST_BUSY: begin
        if (frame_n && irdy_n) state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        release_out = 1'b1;
      end
    endcase
    if (release_out) begin
      devsel_d = 1'b1;
      trdy_d   = 1'b1;
      stop_d   = 1'b1;
      f_d      = 1'b1;
      re_d     = 1'b0;
      we_d     = 1'b0;
      be_d     = '0;
      addr_d   = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      devsel_q <= 1'b1;
      trdy_q   <= 1'b1;
      stop_q   <= 1'b1;
      f_q      <= 1'b1;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      devsel_q <= devsel_d;
      trdy_q   <= trdy_d;
      stop_q   <= stop_d;
      f_q      <= f_d;
      re_q     <= re_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
    end
  end

  assign devsel_n = devsel_q;
  assign trdy_n   = trdy_q;
  assign stop_n   = stop_q;
  assign f        = f_q;
  assign re       = re_q;
  assign we       = we_q;
  assign be       = be_q;
  assign address  = addr_q;

endmodule

// File: tb/tb_pci_target_ctrl.sv
// tb/tb_pci_target_ctrl.sv - transaction-level PCI master with reference expectations for pci_target_ctrl
module tb_pci_target_ctrl;

  localparam int          DEPTH  = 3;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [11:0] IDLE_V = 12'hF00;

  logic        clk = 1'b0;
  logic        rst_n, frame_n, irdy_n, trdy_control;
  logic [3:0]  cbe_n;
  logic [31:0] ad;
  logic        devsel_n, trdy_n, stop_n, f, re, we;
  logic [3:0]  be;
  logic [1:0]  address;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pci_target_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .frame_n(frame_n), .irdy_n(irdy_n), .cbe_n(cbe_n), .ad(ad),
    .trdy_control(trdy_control), .devsel_n(devsel_n), .trdy_n(trdy_n), .stop_n(stop_n),
    .f(f), .re(re), .we(we), .be(be), .address(address)
  );

  // Packed view: {devsel_n, trdy_n, stop_n, f, re, we, be[3:0], address[1:0]}
  function automatic logic [11:0] outv();
    return {devsel_n, trdy_n, stop_n, f, re, we, be, address};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp, input logic [11:0] mask);
    checks++;
    assert ((obs & mask) === (exp & mask)) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (mask %h) at %0t", tag, obs & mask, exp & mask, mask, $time);
    end
  endtask

  function automatic bit tc_val(input int k, input int s, input int l, input bit rnd);
    if (rnd) return ($urandom_range(0, 3) != 0);
    return !(k >= s && k < s + l);
  endfunction

  task automatic gap(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check("gap_idle", outv(), IDLE_V, 12'hFFF);
      frame_n = 1'b1; irdy_n = 1'b1; trdy_control = 1'($urandom_range(0, 1));
    end
  endtask

  // One master transaction; expectations follow from beats done, cycle index and the stall pattern.
  task automatic run_txn(input logic [31:0] a, input logic [3:0] cmd, input int n,
                         input int st_start, input int st_len, input bit rnd);
    bit hit, wr, last, beat, exp_tr, tc_prev;
    int beats, obs_beats, k, phase, disc_n, hold;
    logic [3:0] cbe_prev;
    logic [11:0] ev;
    string tg;
    hit  = (a[31:4] == BASE[31:4]) && (int'(a[3:2]) < DEPTH) && (cmd == 4'b0110 || cmd == 4'b0111);
    wr   = (cmd == 4'b0111);
    tg   = wr ? "wr_data" : "rd_data";
    hold = rnd ? int'($urandom_range(0, 1)) : 0;
    @(negedge clk);
    check("pre_addr_idle", outv(), IDLE_V, 12'hFFF);
    frame_n = 1'b0; irdy_n = 1'b1; ad = a; cbe_n = cmd;
    tc_prev = tc_val(0, st_start, st_len, rnd); trdy_control = tc_prev;
    cbe_prev = cmd;
    if (!hit) begin
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        check("miss_no_devsel", outv(), IDLE_V, 12'hFFF);
        frame_n = (c >= 4); irdy_n = (c == 5); ad = $urandom;
        trdy_control = 1'($urandom_range(0, 1));
      end
      return;
    end
    beats = 0; obs_beats = 0; phase = 0; disc_n = 0; k = 1;
    while (phase != 2 && k < 200) begin
      @(negedge clk);
      case (phase)
        0: begin
          exp_tr = (!wr && k == 1) ? 1'b1 : !tc_prev;
          ev = {1'b0, exp_tr, 1'b1, 1'b0, !wr, wr, (k == 1) ? 4'h0 : ~cbe_prev, a[3:2]};
          check(tg, outv(), ev, 12'hFFF);
          last    = (beats == n - 1);
          frame_n = last;
          irdy_n  = last ? 1'b0 : (rnd && ($urandom_range(0, 4) == 0));
          cbe_n   = rnd ? 4'($urandom) : 4'h0;
          ad      = $urandom;
          tc_prev = tc_val(k, st_start, st_len, rnd); trdy_control = tc_prev;
          cbe_prev = cbe_n;
          beat = !irdy_n && !exp_tr;
          if (beat) beats++;
          if (beat && last) phase = 2;
          else if (beats == DEPTH) phase = 1;
        end
        1: begin
          check("disconnect", outv(), 12'h400, 12'hE00);
          frame_n = (disc_n >= hold); irdy_n = 1'b0; disc_n++;
          if (frame_n) phase = 3;
        end
        default: begin
          check("post_disc_idle", outv(), IDLE_V, 12'hFFF);
          frame_n = 1'b1; irdy_n = 1'b1; phase = 2;
        end
      endcase
      if (!irdy_n && !trdy_n) obs_beats++;
      k++;
    end
    checks++;
    assert (phase == 2) else begin
      errors++;
      $error("FAIL txn_timeout: observed phase %0d after %0d cycles, expected completion", phase, k);
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; frame_n = 1'b1; irdy_n = 1'b1;
    end
    checks++;
    assert (obs_beats === beats) else begin
      errors++;
      $error("FAIL beat_count: observed %0d expected %0d", obs_beats, beats);
    end
  endtask

  task automatic reset_mid_burst();
    @(negedge clk);
    check("pre_rst_idle", outv(), IDLE_V, 12'hFFF);
    frame_n = 1'b0; irdy_n = 1'b1; ad = 32'h0; cbe_n = 4'b0111; trdy_control = 1'b1;
    @(negedge clk);
    check("rst_wr_first", outv(), 12'h240, 12'hFFF);
    frame_n = 1'b0; irdy_n = 1'b0; cbe_n = 4'h0;
    @(negedge clk);
    check("rst_wr_second", outv(), 12'h27C, 12'hFFF);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outv(), IDLE_V, 12'hFFF);
    @(negedge clk);
    check("reset_held", outv(), IDLE_V, 12'hFFF);
    rst_n = 1'b1; frame_n = 1'b1; irdy_n = 1'b1;
  endtask

  initial begin
    logic [27:0] up;
    logic [1:0]  w;
    logic [3:0]  cmd;
    rst_n = 1'b0; frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'hF; ad = 32'h0; trdy_control = 1'b1;
    repeat (3) @(negedge clk);
    check("reset", outv(), IDLE_V, 12'hFFF);
    rst_n = 1'b1;

    run_txn(32'h0000_0000, 4'b0111, 3, 99, 0, 1'b0);
    gap(1);
    run_txn(32'h0000_0004, 4'b0110, 1, 99, 0, 1'b0);
    run_txn(32'h0000_0100, 4'b0111, 2, 99, 0, 1'b0);
    run_txn(32'h0000_0000, 4'b0111, 4, 99, 0, 1'b0);
    run_txn(32'h0000_0000, 4'b0111, 3, 2, 2, 1'b0);
    run_txn(32'h0000_000C, 4'b0110, 1, 99, 0, 1'b0);
    run_txn(32'h0000_0008, 4'b0010, 1, 99, 0, 1'b0);
    run_txn(32'h0000_0008, 4'b0110, 3, 1, 1, 1'b0);
    run_txn(32'h0000_0004, 4'b0111, 3, 99, 0, 1'b0);
    reset_mid_burst();

    for (int t = 0; t < 60; t++) begin
      gap($urandom_range(0, 2));
      w  = 2'($urandom_range(0, 3));
      up = ($urandom_range(0, 4) == 0) ? 28'($urandom) : BASE[31:4];
      case ($urandom_range(0, 4))
        0, 2:    cmd = 4'b0110;
        1, 3:    cmd = 4'b0111;
        default: cmd = 4'($urandom);
      endcase
      run_txn({up, w, 2'b00}, cmd, $urandom_range(1, 5), 99, 0, 1'b1);
    end
    gap(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
